mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/cpu_pkg.sv | 15 +
 rtl/mem_stage_if.sv | 34 +++
 rtl/mem_wb_reg.sv | 37 +++
 rtl/mem_stage.sv | 101 ++++++++++
 tb/tb_mem_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and widths.
// Holds the MEM-stage FSM state encoding.
package cpu_pkg;

  localparam int data_size   = 32;
  localparam int log_reg_num = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus.
// master = MEM stage, slave = memory.
interface mem_stage_if;
  import cpu_pkg::*;

  logic                 dm_req;
  logic [data_size-1:0] dm_addr;
  logic [3:0]           dm_we;
  logic [data_size-1:0] dm_wdata;
  logic                 dm_ready;
  logic                 dm_rvalid;
  logic [data_size-1:0] dm_rdata;

  modport master (
    output dm_req,
    output dm_addr,
    output dm_we,
    output dm_wdata,
    input  dm_ready,
    input  dm_rvalid,
    input  dm_rdata
  );

  modport slave (
    input  dm_req,
    input  dm_addr,
    input  dm_we,
    input  dm_wdata,
    output dm_ready,
    output dm_rvalid,
    output dm_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Loads every cycle unless held; never bubbles.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   hold_i,
  input  logic [data_size-1:0]   data_i,
  input  logic [log_reg_num-1:0] rd_i,
  input  logic                   regwrite_i,
  output logic [data_size-1:0]   data_o,
  output logic [log_reg_num-1:0] rd_o,
  output logic                   regwrite_o
);

  logic [data_size-1:0]   data_q;
  logic [log_reg_num-1:0] rd_q;
  logic                   regwrite_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else if (!hold_i) begin
      data_q     <= data_i;
      rd_q       <= rd_i;
      regwrite_q <= regwrite_i;
    end
  end

  assign data_o     = data_q;
  assign rd_o       = rd_q;
  assign regwrite_o = regwrite_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory FSM, store lanes,
// load extension and the MEM/WB register.
module mem_stage
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [data_size-1:0]   ex_result,
  input  logic [data_size-1:0]   ex_data2,
  input  logic [log_reg_num-1:0] ex_rd,
  input  logic                   ex_memtoreg,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic                   ex_memwrite,
  input  logic                   ex_ls_word,
  mem_stage_if.master            dm,
  output logic                   d_stall,
  output logic [data_size-1:0]   wb_data,
  output logic [log_reg_num-1:0] wb_rd,
  output logic                   wb_regwrite
);

  mem_state_e           state_q, state_d;
  logic [data_size-1:0] lbuf_q, lbuf_d;

  logic                 mem_op;
  logic                 is_store;
  logic [1:0]           boff;
  logic [3:0]           we_lane;
  logic [data_size-1:0] wdata_lane;
  logic [7:0]           lbyte;
  logic [data_size-1:0] load_val;
  logic [data_size-1:0] wb_data_d;

  assign mem_op   = ex_memread | ex_memwrite;
  // memread+memwrite together behaves as a store
  assign is_store = ex_memwrite;
  assign boff     = ex_result[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      lbuf_q  <= lbuf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lbuf_d    = lbuf_q;
    dm.dm_req = 1'b0;
    unique case (state_q)
      IDLE: if (mem_op) state_d = REQ;
      REQ: begin
        dm.dm_req = 1'b1;
        if (dm.dm_ready) state_d = WAIT;
      end
      WAIT: if (dm.dm_rvalid) begin
        lbuf_d  = dm.dm_rdata;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (ex_ls_word) begin
      we_lane    = 4'hF;
      wdata_lane = ex_data2;
    end else begin
      we_lane    = 4'b0001 << boff;
      wdata_lane = {4{ex_data2[7:0]}};
    end
  end

  // Inputs are frozen by d_stall, so these stay stable through REQ
  assign dm.dm_addr  = ex_result;
  assign dm.dm_we    = (state_q == REQ && is_store) ? we_lane : 4'h0;
  assign dm.dm_wdata = (state_q == REQ && is_store) ? wdata_lane : '0;

  assign lbyte    = lbuf_q[{boff, 3'b000} +: 8];
  assign load_val = ex_ls_word ? lbuf_q : {{24{lbyte[7]}}, lbyte};

  assign wb_data_d = ex_memtoreg ? load_val : ex_result;
  assign d_stall   = mem_op && (state_q != DONE);

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .rst_ni     (rst),
    .hold_i     (d_stall),
    .data_i     (wb_data_d),
    .rd_i       (ex_rd),
    .regwrite_i (ex_regwrite),
    .data_o     (wb_data),
    .rd_o       (wb_rd),
    .regwrite_o (wb_regwrite)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus
// random ops checked against a transaction model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ex_result;
  logic [31:0] ex_data2;
  logic [4:0]  ex_rd;
  logic        ex_memtoreg;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_ls_word;
  logic        d_stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;

  mem_stage_if dmif ();

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .ex_result   (ex_result),
    .ex_data2    (ex_data2),
    .ex_rd       (ex_rd),
    .ex_memtoreg (ex_memtoreg),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_ls_word  (ex_ls_word),
    .dm          (dmif),
    .d_stall     (d_stall),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] exp_wd;
  logic [4:0]  exp_rd;
  logic        exp_rw;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_hold_data"}, wb_data, exp_wd);
    chk({tag, "_hold_rd"}, {27'd0, wb_rd}, {27'd0, exp_rd});
  endtask

  // One instruction through MEM; starts just after a
  // rising edge with the FSM idle, ends the same way.
  task automatic do_op(input bit rd_en, input bit wr_en,
                       input bit word, input bit m2r,
                       input bit rw, input logic [4:0] rd,
                       input logic [31:0] res,
                       input logic [31:0] d2,
                       input logic [31:0] rdat,
                       input int rdy_dly, input int val_dly);
    logic [3:0]  e_we;
    logic [31:0] e_wdat;
    logic [31:0] e_lv;
    logic [31:0] b;
    int          a;
    bit          mem;

    ex_memread  = rd_en;
    ex_memwrite = wr_en;
    ex_ls_word  = word;
    ex_memtoreg = m2r;
    ex_regwrite = rw;
    ex_rd       = rd;
    ex_result   = res;
    ex_data2    = d2;
    dmif.dm_ready  = 1'b0;
    dmif.dm_rvalid = 1'b0;

    mem = rd_en | wr_en;
    a   = int'(res % 4);
    if (!wr_en) begin
      e_we   = 4'h0;
      e_wdat = 32'h0;
    end else if (word) begin
      e_we   = 4'hF;
      e_wdat = d2;
    end else begin
      e_we   = 4'(1 << a);
      e_wdat = (d2 & 32'hFF) * 32'h0101_0101;
    end
    if (word) e_lv = rdat;
    else begin
      b    = (rdat >> (8 * a)) & 32'hFF;
      e_lv = (b >= 32'd128) ? b - 32'd256 : b;
    end

    #1;
    if (mem) begin
      chk("idle_stall", {31'd0, d_stall}, 32'd1);
      chk("idle_req", {31'd0, dmif.dm_req}, 32'd0);
      chk("idle_we", {28'd0, dmif.dm_we}, 32'd0);
      dmif.dm_ready  = 1'($urandom_range(1));
      dmif.dm_rvalid = 1'($urandom_range(1));
      @(posedge clk); #1;
      dmif.dm_rvalid = 1'b0;
      for (int k = 0; k <= rdy_dly; k++) begin
        dmif.dm_ready = (k == rdy_dly);
        #1;
        chk("req_req", {31'd0, dmif.dm_req}, 32'd1);
        chk("req_addr", dmif.dm_addr, res);
        chk("req_we", {28'd0, dmif.dm_we}, {28'd0, e_we});
        if (wr_en) chk("req_wdata", dmif.dm_wdata, e_wdat);
        chk("req_stall", {31'd0, d_stall}, 32'd1);
        chk_hold("req");
        @(posedge clk); #1;
      end
      dmif.dm_ready = 1'b0;
      for (int k = 0; k <= val_dly; k++) begin
        dmif.dm_rvalid = (k == val_dly);
        dmif.dm_rdata  = (k == val_dly) ? rdat : $urandom;
        #1;
        chk("wait_req", {31'd0, dmif.dm_req}, 32'd0);
        chk("wait_we", {28'd0, dmif.dm_we}, 32'd0);
        chk("wait_wdata", dmif.dm_wdata, 32'd0);
        chk("wait_stall", {31'd0, d_stall}, 32'd1);
        chk_hold("wait");
        @(posedge clk); #1;
      end
      dmif.dm_rvalid = 1'b0;
      dmif.dm_rdata  = $urandom;
      #1;
      chk("done_stall", {31'd0, d_stall}, 32'd0);
      chk("done_req", {31'd0, dmif.dm_req}, 32'd0);
      @(posedge clk); #1;
    end else begin
      chk("alu_stall", {31'd0, d_stall}, 32'd0);
      chk("alu_req", {31'd0, dmif.dm_req}, 32'd0);
      @(posedge clk); #1;
    end

    exp_wd = m2r ? e_lv : res;
    exp_rd = rd;
    exp_rw = rw;
    chk("wb_data", wb_data, exp_wd);
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd});
    chk("wb_rw", {31'd0, wb_regwrite}, {31'd0, exp_rw});
  endtask

  initial begin
    rst = 1'b0;
    ex_result = '0; ex_data2 = '0; ex_rd = '0;
    ex_memtoreg = 0; ex_regwrite = 0;
    ex_memread = 0; ex_memwrite = 0; ex_ls_word = 0;
    dmif.dm_ready = 0; dmif.dm_rvalid = 0;
    dmif.dm_rdata = '0;
    exp_wd = '0; exp_rd = '0; exp_rw = 1'b0;

    #3;
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_rw", {31'd0, wb_regwrite}, 32'd0);
    chk("rst_req", {31'd0, dmif.dm_req}, 32'd0);
    chk("rst_stall", {31'd0, d_stall}, 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // ALU op, word load, byte load, byte store
    do_op(0, 0, 1, 0, 1, 5'd5, 32'h1234, 32'h0,
          32'h0, 0, 0);
    do_op(1, 0, 1, 1, 1, 5'd7, 32'h100, 32'h0,
          32'hDEAD_BEEF, 2, 2);
    do_op(1, 0, 0, 1, 1, 5'd8, 32'h103, 32'h0,
          32'h80FF_0000, 0, 1);
    do_op(0, 1, 0, 0, 0, 5'd0, 32'h102, 32'hAB,
          32'h0, 3, 0);
    // load immediately followed by an add
    do_op(1, 0, 1, 1, 1, 5'd9, 32'h200, 32'h0,
          32'h1111_2222, 1, 0);
    do_op(0, 0, 1, 0, 1, 5'd10, 32'h3333, 32'h0,
          32'h0, 0, 0);

    // reset while waiting on a store response
    ex_memread = 0; ex_memwrite = 1; ex_ls_word = 0;
    ex_memtoreg = 0; ex_regwrite = 0; ex_rd = 5'd0;
    ex_result = 32'h102; ex_data2 = 32'hAB;
    @(posedge clk); #1;
    dmif.dm_ready = 1'b1;
    @(posedge clk); #1;
    dmif.dm_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, dmif.dm_req}, 32'd0);
    chk("mid_rst_we", {28'd0, dmif.dm_we}, 32'd0);
    chk("mid_rst_wdata", dmif.dm_wdata, 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("mid_rst_wb_rw", {31'd0, wb_regwrite}, 32'd0);
    exp_wd = '0; exp_rd = '0; exp_rw = 1'b0;
    #1 rst = 1'b1;
    #1;
    do_op(0, 1, 0, 0, 0, 5'd0, 32'h102, 32'hAB,
          32'h0, 1, 1);

    // mixed random traffic
    for (int i = 0; i < 80; i++) begin
      int          kind;
      bit          w;
      logic [31:0] r;
      kind = int'($urandom_range(3));
      w    = 1'($urandom_range(1));
      r    = $urandom;
      case (kind)
        0: do_op(0, 0, w, 0, 1'($urandom_range(1)),
                 5'($urandom), r, $urandom, $urandom, 0, 0);
        1: do_op(1, 0, w, 1, 1, 5'($urandom), r, $urandom,
                 $urandom, int'($urandom_range(3)),
                 int'($urandom_range(3)));
        2: do_op(0, 1, w, 0, 0, 5'($urandom), r, $urandom,
                 $urandom, int'($urandom_range(3)),
                 int'($urandom_range(3)));
        default: do_op(1, 1, w, 0, 0, 5'($urandom), r,
                       $urandom, $urandom,
                       int'($urandom_range(2)),
                       int'($urandom_range(2)));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
